// File: rtl/keyfile_reader_seq_if.sv
// keyfile_reader_seq_if
//   Bus bundle for the keyfile reader peripheral: openMSP430 peripheral
//   access signals plus the keyfile source.
//   master : CPU / bus side, drives the access and the key source.
//   slave  : the peripheral, returns per_dout.
//   Signals:
//     per_addr[13:0]   word address
//     per_din[15:0]    write data
//     per_en           access enable
//     per_we[1:0]      byte write enables (any bit = word write)
//     smclk_en         SMCLK enable (not used by the reader)
//     key_data_in      keyfile, word 0 in the MSBs
//     key_valid        keyfile source stable and valid
//     per_dout[15:0]   read data, 0 when not selected
interface keyfile_reader_seq_if #(
  parameter int KEY_WORDS = 4
);
  logic [13:0]             per_addr;
  logic [15:0]             per_din;
  logic                    per_en;
  logic [1:0]              per_we;
  logic                    smclk_en;
  logic [16*KEY_WORDS-1:0] key_data_in;
  logic                    key_valid;
  logic [15:0]             per_dout;

  modport master (
    output per_addr, per_din, per_en, per_we, smclk_en, key_data_in, key_valid,
    input  per_dout
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we, smclk_en, key_data_in, key_valid,
    output per_dout
  );
endinterface

// File: rtl/keyfile_reader_seq.sv
// keyfile_reader_seq
//   Read-only snapshot window onto a keyfile. A CTRL write (SNAP) copies the
//   keyfile into a shadow register one word per cycle while key_valid holds;
//   software then reads the shadow through an auto-incrementing IDX/DATA pair.
//   LOCK (or the optional read budget) blanks the shadow until puc_rst.
//   Ports:
//     mclk     system clock, all state on the rising edge
//     puc_rst  asynchronous active-high reset
//     bus      keyfile_reader_seq_if.slave (peripheral bus + key source)
//   Registers (byte offsets): 0x0 CTRL, 0x2 STAT, 0x4 IDX, 0x6 DATA.
//
//   state  | meaning
//   S_IDLE | no copy in progress, DATA readable if VALID
//   S_WAIT | SNAP accepted, waiting for key_valid
//   S_COPY | copying words 1..KEY_WORDS-1 (word 0 copied on WAIT exit)
module keyfile_reader_seq #(
  parameter logic [14:0] BASE_ADDR = 15'h01A8,
  parameter int          KEY_WORDS = 4,
  parameter int          MAX_READS = 0
) (
  input logic               mclk,
  input logic               puc_rst,
  keyfile_reader_seq_if.slave bus
);
  localparam int         IW       = $clog2(KEY_WORDS);
  localparam int         DEC_WD   = 3;
  localparam logic [7:0] MAX_RD   = 8'(MAX_READS);
  localparam bit         LIMIT_EN = (MAX_READS != 0);
  localparam logic [IW-1:0] LAST  = IW'(KEY_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COPY} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    rd_cnt_q, rd_cnt_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic [15:0]   shadow_q [KEY_WORDS];
  logic [15:0]   key_w    [KEY_WORDS];

  logic        sel, rd, wr;
  logic [1:0]  reg_sel;
  logic        snap_cmd, lock_cmd, clr_cmd, idx_wr;
  logic        busy, data_ok, data_rd;
  logic        snap_go, copy_en, copy_last, abort, auto_lock, wipe;
  logic [7:0]  rd_cnt_inc;
  logic [IW-1:0] idx_inc;
  logic [15:0] stat, dout;
  logic        unused_smclk;

  assign unused_smclk = bus.smclk_en;

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign key_w[g] = bus.key_data_in[16*(KEY_WORDS-g)-1 -: 16];
  end

  // Address decode: 8-byte window, register picked by the low word-address bits.
  assign sel     = bus.per_en & (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_sel = bus.per_addr[1:0];
  assign rd      = sel & ~|bus.per_we;
  assign wr      = sel &  |bus.per_we;

  assign snap_cmd = wr & (reg_sel == 2'd0) & bus.per_din[0];
  assign lock_cmd = wr & (reg_sel == 2'd0) & bus.per_din[1];
  assign clr_cmd  = wr & (reg_sel == 2'd0) & bus.per_din[2];
  assign idx_wr   = wr & (reg_sel == 2'd2);

  assign busy    = (state_q != S_IDLE);
  assign data_ok = valid_q & ~locked_q & ~busy;
  assign data_rd = rd & (reg_sel == 2'd3) & data_ok;

  assign rd_cnt_inc = (rd_cnt_q == 8'hFF) ? 8'hFF : rd_cnt_q + 8'd1;
  assign idx_inc    = (idx_q == LAST) ? '0 : idx_q + IW'(1);

  // LOCK and CLR pre-empt any copy activity in the same cycle.
  assign snap_go   = snap_cmd & ~lock_cmd & ~clr_cmd & ~busy & ~locked_q;
  assign copy_en   = ((state_q == S_WAIT) | (state_q == S_COPY)) & bus.key_valid
                     & ~lock_cmd & ~clr_cmd;
  assign copy_last = copy_en & (cnt_q == LAST);
  assign abort     = (state_q == S_COPY) & ~bus.key_valid & ~lock_cmd & ~clr_cmd;
  // The read that spends the budget still returns data; the lock lands on its edge.
  assign auto_lock = LIMIT_EN & data_rd & (rd_cnt_inc == MAX_RD);
  assign wipe      = lock_cmd | clr_cmd | abort | auto_lock;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rd_cnt_d = rd_cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    locked_d = locked_q;

    if (idx_wr) begin
      idx_d = (bus.per_din < 16'(KEY_WORDS)) ? bus.per_din[IW-1:0] : '0;
    end

    if (data_rd) begin
      idx_d    = idx_inc;
      rd_cnt_d = rd_cnt_inc;
      if (auto_lock) begin
        locked_d = 1'b1;
        valid_d  = 1'b0;
      end
    end

    if (lock_cmd | clr_cmd) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      if (lock_cmd) locked_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (snap_go) begin
            state_d  = S_WAIT;
            valid_d  = 1'b0;
            err_d    = 1'b0;
            rd_cnt_d = '0;
            cnt_d    = '0;
          end
        end
        S_WAIT, S_COPY: begin
          if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end else if (copy_last) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
          end else if (copy_en) begin
            state_d = S_COPY;
            cnt_d   = cnt_q + IW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      rd_cnt_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rd_cnt_q <= rd_cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      for (int i = 0; i < KEY_WORDS; i++) shadow_q[i] <= '0;
    end else if (wipe) begin
      for (int i = 0; i < KEY_WORDS; i++) shadow_q[i] <= '0;
    end else if (copy_en) begin
      shadow_q[cnt_q] <= key_w[cnt_q];
    end
  end

  assign stat = {rd_cnt_q, 4'b0000, err_q, locked_q, valid_q, busy};

  always_comb begin
    dout = '0;
    if (rd) begin
      case (reg_sel)
        2'd1:    dout = stat;
        2'd2:    dout = {{(16-IW){1'b0}}, idx_q};
        2'd3:    dout = data_ok ? shadow_q[idx_q] : 16'h0000;
        default: dout = '0;
      endcase
    end
  end

  assign bus.per_dout = dout;
endmodule

// File: tb/tb_keyfile_reader_seq.sv
module tb_keyfile_reader_seq;
  localparam logic [13:0] A_CTRL = 14'h00D4;
  localparam logic [13:0] A_STAT = 14'h00D5;
  localparam logic [13:0] A_IDX  = 14'h00D6;
  localparam logic [13:0] A_DATA = 14'h00D7;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic        key_valid = 1'b0;
  logic [63:0] key_val = 64'h0123_4567_89AB_CDEF;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  always #5 mclk = ~mclk;

  keyfile_reader_seq_if #(.KEY_WORDS(4)) if0 ();
  keyfile_reader_seq_if #(.KEY_WORDS(4)) if1 ();

  assign if0.per_addr = per_addr;    assign if1.per_addr = per_addr;
  assign if0.per_din = per_din;      assign if1.per_din = per_din;
  assign if0.per_en = per_en;        assign if1.per_en = per_en;
  assign if0.per_we = per_we;        assign if1.per_we = per_we;
  assign if0.smclk_en = 1'b1;        assign if1.smclk_en = 1'b1;
  assign if0.key_data_in = key_val;  assign if1.key_data_in = key_val;
  assign if0.key_valid = key_valid;  assign if1.key_valid = key_valid;

  keyfile_reader_seq #(.BASE_ADDR(15'h01A8), .KEY_WORDS(4), .MAX_READS(0)) u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .bus(if0)
  );

  keyfile_reader_seq #(.BASE_ADDR(15'h01A8), .KEY_WORDS(4), .MAX_READS(3)) u_dut_lim (
    .mclk(mclk), .puc_rst(puc_rst), .bus(if1)
  );

  function automatic logic [15:0] key_word(input int i);
    return key_val[16*(4-i)-1 -: 16];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] data);
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b11; per_addr = addr; per_din = data;
    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00;
  endtask

  // One-cycle read: expectation queued at drive time, popped when sampled.
  task automatic rd(input string tag, input logic [13:0] addr, input bit lim,
                    input logic [15:0] exp, input logic [15:0] mask = 16'hFFFF);
    logic [15:0] obs;
    @(negedge mclk);
    per_en = 1'b1; per_we = 2'b00; per_addr = addr;
    exp_q.push_back(exp & mask);
    tag_q.push_back(tag);
    #2;
    obs = (lim ? if1.per_dout : if0.per_dout) & mask;
    check(tag_q.pop_front(), obs, exp_q.pop_front());
    @(posedge mclk); #1;
    per_en = 1'b0;
  endtask

  task automatic reset_pulse();
    puc_rst = 1'b1;
    @(posedge mclk); #1;
    puc_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_dout_idle", if0.per_dout, 16'h0000);
    rd("rst_stat", A_STAT, 0, 16'h0000);
    rd("rst_idx", A_IDX, 0, 16'h0000);
    rd("rst_data", A_DATA, 0, 16'h0000);
    puc_rst = 1'b0;

    // Basic snapshot and auto-incrementing reads
    key_valid = 1'b1;
    wr(A_CTRL, 16'h0001);
    for (int c = 1; c <= 4; c++) rd("t1_busy", A_STAT, 0, 16'h0001);
    rd("t1_stat_done", A_STAT, 0, 16'h0002);
    for (int i = 0; i < 4; i++) rd("t1_data", A_DATA, 0, key_word(i));
    rd("t1_data_wrap", A_DATA, 0, key_word(0));
    rd("t1_rdcnt", A_STAT, 0, 16'h0502);

    // Snapshot stalled in WAIT for 10 cycles (IDX is 1 going in)
    key_valid = 1'b0;
    wr(A_CTRL, 16'h0001);
    for (int c = 1; c <= 14; c++) begin
      key_valid = (c > 10);
      if (c == 14)          rd("t2_idx_hold", A_IDX, 0, 16'h0001);
      else if (c % 2 == 1)  rd("t2_busy", A_STAT, 0, 16'h0001);
      else                  rd("t2_data_busy", A_DATA, 0, 16'h0000);
    end
    rd("t2_stat_done", A_STAT, 0, 16'h0002);
    rd("t2_data0", A_DATA, 0, key_word(0));

    // key_valid dropped mid-copy
    key_valid = 1'b1;
    wr(A_CTRL, 16'h0001);
    rd("t3_busy", A_STAT, 0, 16'h0001);
    rd("t3_busy", A_STAT, 0, 16'h0001);
    key_valid = 1'b0;
    rd("t3_busy_abort", A_STAT, 0, 16'h0001);
    rd("t3_err", A_STAT, 0, 16'h0008);
    rd("t3_data_err", A_DATA, 0, 16'h0000);
    rd("t3_err_hold", A_STAT, 0, 16'h0008);
    key_valid = 1'b1;
    wr(A_CTRL, 16'h0001);
    for (int c = 1; c <= 4; c++) rd("t3_rebusy", A_STAT, 0, 16'h0001);
    rd("t3_recover", A_STAT, 0, 16'h0002);
    rd("t3_data0", A_DATA, 0, key_word(0));

    // IDX writes, range clamp, LOCK+CLR
    wr(A_IDX, 16'h0002);
    rd("t5_data_idx2", A_DATA, 0, key_word(2));
    wr(A_IDX, 16'h0007);
    rd("t5_idx_oor", A_IDX, 0, 16'h0000);
    wr(A_IDX, 16'h0003);
    rd("t5_idx_last", A_IDX, 0, 16'h0003);
    wr(A_IDX, 16'h0004);
    rd("t5_idx_eq_kw", A_IDX, 0, 16'h0000);
    wr(A_CTRL, 16'h0006);
    rd("t5_lock_clr", A_STAT, 0, 16'h0204);
    rd("t5_ctrl_rd", A_CTRL, 0, 16'h0000);
    rd("t5_data_locked", A_DATA, 0, 16'h0000);
    wr(A_CTRL, 16'h0001);
    rd("t5_snap_ignored", A_STAT, 0, 16'h0204);

    // Reset mid-copy and out-of-window reads
    reset_pulse();
    rd("t6_unlocked", A_STAT, 0, 16'h0000);
    wr(A_CTRL, 16'h0001);
    rd("t6_busy", A_STAT, 0, 16'h0001);
    rd("t6_busy", A_STAT, 0, 16'h0001);
    puc_rst = 1'b1;
    rd("t6_rst_stat", A_STAT, 0, 16'h0000);
    rd("t6_rst_data", A_DATA, 0, 16'h0000);
    puc_rst = 1'b0;
    rd("t6_post_stat", A_STAT, 0, 16'h0000);
    rd("t6_post_data", A_DATA, 0, 16'h0000);
    rd("t6_out_hi", 14'h00D8, 0, 16'h0000);
    rd("t6_out_lo", 14'h00D3, 0, 16'h0000);

    // Read budget of 3 on the second instance
    wr(A_CTRL, 16'h0001);
    for (int c = 1; c <= 4; c++) rd("t4_busy", A_STAT, 1, 16'h0001);
    rd("t4_done", A_STAT, 1, 16'h0002);
    for (int i = 0; i < 3; i++) rd("t4_data", A_DATA, 1, key_word(i));
    rd("t4_locked", A_STAT, 1, 16'h0004, 16'h0004);
    rd("t4_data_locked", A_DATA, 1, 16'h0000);
    rd("t4_unlimited", A_DATA, 0, key_word(0));
    wr(A_CTRL, 16'h0001);
    rd("t4_snap_ignored", A_STAT, 1, 16'h0004, 16'h0005);
    rd("t4_data_still0", A_DATA, 1, 16'h0000);
    reset_pulse();
    rd("t4_reset_unlock", A_STAT, 1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
